// File: rtl/mesi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mesi_mem_ctrl
// Purpose  : Shared memory controller and round-robin bus arbiter for two
//            MESI cache cores. It accepts BusRd / BusRdX / BusUpgr / Flush,
//            broadcasts a snoop to the peer core, and serves data from a
//            peer flush or from a small backing memory. Every data-bearing
//            transaction gets exactly one response pulse.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            req_valid/ready/op/addr/data - per-core request channel
//            snp_req_*             - snoop broadcast to the peer core
//            snp_flush/shared/data - per-core snoop replies
//            rsp_valid/pid/data/shared - response to the requesting core
//            busy                  - controller not in IDLE
//            stat_mem_rd/peer_fwd/wb - saturating event counters, present
//                                    only when MESI_MEM_CTRL_STATS_EN is
//                                    defined
// Revision : 1.0 - initial release
// ============================================================================
module mesi_mem_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int MEM_LAT   = 2,
    parameter int SNOOP_WIN = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [5:0]            req_op,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_data,
    output logic                  snp_req_valid,
    output logic                  snp_req_pid,
    output logic [2:0]            snp_req_op,
    output logic [ADDR_W-1:0]     snp_req_addr,
    input  logic [1:0]            snp_flush,
    input  logic [1:0]            snp_shared,
    input  logic [2*DATA_W-1:0]   snp_data,
    output logic                  rsp_valid,
    output logic                  rsp_pid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_shared,
    output logic                  busy
`ifdef MESI_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]           stat_mem_rd,
    output logic [15:0]           stat_peer_fwd,
    output logic [15:0]           stat_wb
`endif
);

    localparam int c_DEPTH   = 1 << ADDR_W;
    localparam int c_CNT_MAX = (MEM_LAT > SNOOP_WIN) ? MEM_LAT : SNOOP_WIN;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_SW_LAST = c_CNT_W'(SNOOP_WIN - 1);
    localparam logic [c_CNT_W-1:0] c_ML_LAST = c_CNT_W'(MEM_LAT - 1);

    localparam logic [2:0] c_OP_RD    = 3'b001;
    localparam logic [2:0] c_OP_RDX   = 3'b010;
    localparam logic [2:0] c_OP_UPGR  = 3'b011;
    localparam logic [2:0] c_OP_FLUSH = 3'b100;

    localparam int         c_ST_W   = 3;
    localparam logic [c_ST_W-1:0] c_IDLE  = 3'd0;
    localparam logic [c_ST_W-1:0] c_WB    = 3'd1;
    localparam logic [c_ST_W-1:0] c_UPG   = 3'd2;
    localparam logic [c_ST_W-1:0] c_SNOOP = 3'd3;
    localparam logic [c_ST_W-1:0] c_SWAIT = 3'd4;
    localparam logic [c_ST_W-1:0] c_MEM   = 3'd5;
    localparam logic [c_ST_W-1:0] c_RESP  = 3'd6;

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_next_state;

    logic               r_last_grant;
    logic               r_pid;
    logic [2:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_shared_seen;
    logic [DATA_W-1:0]  r_mem [c_DEPTH];

    logic               r_rsp_pid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_shared;

    logic [1:0]         w_grant;
    logic               w_pref;
    logic               w_hs;
    logic               w_gnt_id;
    logic [2:0]         w_gnt_op;
    logic [ADDR_W-1:0]  w_gnt_addr;
    logic [DATA_W-1:0]  w_gnt_data;
    logic               w_peer;
    logic               w_peer_flush;
    logic               w_peer_shared;
    logic [DATA_W-1:0]  w_peer_data;
    logic [DATA_W-1:0]  w_mem_rd;
    logic               w_swait_last;
    logic               w_mem_last;

    // ------------------------------------------------------------------
    // Arbiter: only an idle controller grants, and only to a requesting
    // core. The core that did not win last time is preferred.
    // ------------------------------------------------------------------
    assign w_pref = ~r_last_grant;

    always_comb begin
        w_grant = 2'b00;
        if (r_state == c_IDLE) begin
            if (req_valid[w_pref]) begin
                w_grant[w_pref] = 1'b1;
            end else if (req_valid[r_last_grant]) begin
                w_grant[r_last_grant] = 1'b1;
            end
        end
    end

    assign w_hs       = |w_grant;
    assign w_gnt_id   = w_grant[1];
    assign w_gnt_op   = w_gnt_id ? req_op[5:3] : req_op[2:0];
    assign w_gnt_addr = w_gnt_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign w_gnt_data = w_gnt_id ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

    // Only the non-requesting core's snoop reply matters.
    assign w_peer        = ~r_pid;
    assign w_peer_flush  = snp_flush[w_peer];
    assign w_peer_shared = snp_shared[w_peer];
    assign w_peer_data   = w_peer ? snp_data[2*DATA_W-1:DATA_W] : snp_data[DATA_W-1:0];

    assign w_mem_rd     = r_mem[r_addr];
    assign w_swait_last = (r_cnt == c_SW_LAST);
    assign w_mem_last   = (r_cnt == c_ML_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_hs) begin
                    case (w_gnt_op)
                        c_OP_FLUSH:         w_next_state = c_WB;
                        c_OP_UPGR:          w_next_state = c_UPG;
                        c_OP_RD, c_OP_RDX:  w_next_state = c_SNOOP;
                        default:            w_next_state = c_IDLE; // dropped
                    endcase
                end
            end
            c_WB:    w_next_state = c_IDLE;
            c_UPG:   w_next_state = c_RESP;
            c_SNOOP: w_next_state = c_SWAIT;
            c_SWAIT: begin
                if (w_peer_flush) begin
                    w_next_state = c_RESP;
                end else if (w_swait_last) begin
                    w_next_state = c_MEM;
                end
            end
            c_MEM: begin
                if (w_mem_last) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready     = w_grant;
        busy          = (r_state != c_IDLE);
        snp_req_valid = (r_state == c_SNOOP) || (r_state == c_UPG);
        rsp_valid     = (r_state == c_RESP);
        snp_req_pid   = r_pid;
        snp_req_op    = r_op;
        snp_req_addr  = r_addr;
        rsp_pid       = r_rsp_pid;
        rsp_data      = r_rsp_data;
        rsp_shared    = r_rsp_shared;
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, counters, memory and response registers.
    // Response registers load on entry to RESP and then hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_pid         <= 1'b0;
            r_op          <= 3'b000;
            r_addr        <= '0;
            r_data        <= '0;
            r_cnt         <= '0;
            r_shared_seen <= 1'b0;
            r_rsp_pid     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_shared  <= 1'b0;
            r_mem         <= '{default: {DATA_W{1'b1}}};
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hs) begin
                        r_pid        <= w_gnt_id;
                        r_op         <= w_gnt_op;
                        r_addr       <= w_gnt_addr;
                        r_data       <= w_gnt_data;
                        r_last_grant <= w_gnt_id;
                    end
                end
                c_WB: begin
                    r_mem[r_addr] <= r_data;
                end
                c_UPG: begin
                    r_rsp_pid    <= r_pid;
                    r_rsp_data   <= w_mem_rd;
                    r_rsp_shared <= 1'b0;
                end
                c_SNOOP: begin
                    r_shared_seen <= 1'b0;
                    r_cnt         <= '0;
                end
                c_SWAIT: begin
                    // A flush in the same cycle as a shared reply takes priority.
                    if (w_peer_flush) begin
                        r_mem[r_addr] <= w_peer_data;
                        r_rsp_pid     <= r_pid;
                        r_rsp_data    <= w_peer_data;
                        r_rsp_shared  <= (r_op == c_OP_RD);
                    end else begin
                        if (w_peer_shared) begin
                            r_shared_seen <= 1'b1;
                        end
                        if (w_swait_last) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_MEM: begin
                    if (w_mem_last) begin
                        r_rsp_pid    <= r_pid;
                        r_rsp_data   <= w_mem_rd;
                        r_rsp_shared <= r_shared_seen && (r_op == c_OP_RD);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MESI_MEM_CTRL_STATS_EN
    logic [15:0] r_stat_mem_rd;
    logic [15:0] r_stat_peer_fwd;
    logic [15:0] r_stat_wb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_mem_rd   <= '0;
            r_stat_peer_fwd <= '0;
            r_stat_wb       <= '0;
        end else begin
            if ((r_state == c_MEM) && w_mem_last && (r_stat_mem_rd != 16'hFFFF)) begin
                r_stat_mem_rd <= r_stat_mem_rd + 16'd1;
            end
            if ((r_state == c_SWAIT) && w_peer_flush && (r_stat_peer_fwd != 16'hFFFF)) begin
                r_stat_peer_fwd <= r_stat_peer_fwd + 16'd1;
            end
            if ((r_state == c_WB) && (r_stat_wb != 16'hFFFF)) begin
                r_stat_wb <= r_stat_wb + 16'd1;
            end
        end
    end

    assign stat_mem_rd   = r_stat_mem_rd;
    assign stat_peer_fwd = r_stat_peer_fwd;
    assign stat_wb       = r_stat_wb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesi_mem_ctrl
// Purpose  : Self-checking bench for mesi_mem_ctrl. A transaction-level
//            model predicts grants, busy, snoop broadcasts and responses
//            from latency formulas; a compare process checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesi_mem_ctrl;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int MEM_LAT   = 2;
    localparam int SNOOP_WIN = 2;

    localparam logic [2:0] RD = 3'b001, RDX = 3'b010, UPG = 3'b011, FL = 3'b100;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           req_valid, req_ready;
    logic [5:0]           req_op;
    logic [2*ADDR_W-1:0]  req_addr;
    logic [2*DATA_W-1:0]  req_data;
    logic                 snp_req_valid, snp_req_pid;
    logic [2:0]           snp_req_op;
    logic [ADDR_W-1:0]    snp_req_addr;
    logic [1:0]           snp_flush, snp_shared;
    logic [2*DATA_W-1:0]  snp_data;
    logic                 rsp_valid, rsp_pid, rsp_shared, busy;
    logic [DATA_W-1:0]    rsp_data;

    always #5 clk = ~clk;

    mesi_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .SNOOP_WIN(SNOOP_WIN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .snp_req_valid(snp_req_valid), .snp_req_pid(snp_req_pid),
        .snp_req_op(snp_req_op), .snp_req_addr(snp_req_addr),
        .snp_flush(snp_flush), .snp_shared(snp_shared), .snp_data(snp_data),
        .rsp_valid(rsp_valid), .rsp_pid(rsp_pid), .rsp_data(rsp_data),
        .rsp_shared(rsp_shared), .busy(busy)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    // model state
    logic [7:0] m_mem [16];
    int         m_lg, m_free_at;
    bit         p_valid [2];
    logic [2:0] p_op [2];
    logic [3:0] p_addr [2];
    logic [7:0] p_data [2];
    int         s_fk [2], s_sk [2];
    logic [7:0] s_fd [2];
    bit         s_junk [2];
    bit         t_act;
    int         t_pid, t_hs, t_fk, t_sk;
    logic [2:0] t_op;
    logic [3:0] t_addr;
    logic [7:0] t_fd;
    bit         t_junk;
    int         e_rsp_cyc, e_pid;
    logic [7:0] e_data;
    bit         e_sh;
    int         h_pid;
    logic [7:0] h_data;
    bit         h_sh;
    logic [1:0] x_ready;
    bit         x_busy, x_snp, x_rsp;
    // observations for literal checks
    int         obs_q [$];
    int         obs_cyc, nobs;
    logic [7:0] obs_data;
    bit         obs_sh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hFF;
        m_lg = 1; e_rsp_cyc = -1; t_act = 1'b0;
        h_pid = 0; h_data = 8'h00; h_sh = 1'b0;
        p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    endtask

    // Apply inputs for the current cycle and compute the expected outputs.
    task automatic drive();
        int k, peer, pref;
        req_valid = {p_valid[1], p_valid[0]};
        req_op    = {p_op[1], p_op[0]};
        req_addr  = {p_addr[1], p_addr[0]};
        req_data  = {p_data[1], p_data[0]};
        snp_flush = 2'b00; snp_shared = 2'b00; snp_data = '0;
        if (t_act && (t_op == RD || t_op == RDX) && cyc >= t_hs + 2 && cyc <= t_hs + 1 + SNOOP_WIN) begin
            k = cyc - t_hs - 2;
            peer = 1 - t_pid;
            if (t_junk) begin
                snp_flush[t_pid] = 1'b1; snp_shared[t_pid] = 1'b1;
                snp_data[t_pid*8 +: 8] = 8'h77;
            end
            if (k == t_fk) begin snp_flush[peer] = 1'b1; snp_data[peer*8 +: 8] = t_fd; end
            if (k == t_sk) snp_shared[peer] = 1'b1;
        end
        x_busy  = (cyc < m_free_at);
        x_ready = 2'b00;
        if (!x_busy && !reset) begin
            pref = 1 - m_lg;
            if (p_valid[pref]) x_ready[pref] = 1'b1;
            else if (p_valid[1-pref]) x_ready[1-pref] = 1'b1;
        end else if (!x_busy) begin
            pref = 1 - m_lg;
            if (p_valid[pref]) x_ready[pref] = 1'b1;
            else if (p_valid[1-pref]) x_ready[1-pref] = 1'b1;
        end
        x_snp = t_act && (cyc == t_hs + 1) && (t_op == RD || t_op == RDX || t_op == UPG);
        x_rsp = (cyc == e_rsp_cyc);
    endtask

    task automatic handshake(input int g);
        int L;
        logic [3:0] a;
        a = p_addr[g];
        t_act = 1'b1; t_pid = g; t_op = p_op[g]; t_addr = a; t_hs = cyc;
        t_fk = s_fk[g]; t_sk = s_sk[g]; t_fd = s_fd[g]; t_junk = s_junk[g];
        m_lg = g; p_valid[g] = 1'b0; e_pid = g;
        e_rsp_cyc = -1;
        case (t_op)
            FL:  begin m_mem[a] = p_data[g]; L = 1; end
            UPG: begin L = 2; e_data = m_mem[a]; e_sh = 1'b0; e_rsp_cyc = cyc + L; end
            RD, RDX: begin
                if (t_fk >= 0 && t_fk < SNOOP_WIN) begin
                    L = 3 + t_fk; e_data = t_fd; m_mem[a] = t_fd; e_sh = (t_op == RD);
                end else begin
                    L = 2 + SNOOP_WIN + MEM_LAT; e_data = m_mem[a];
                    e_sh = (t_sk >= 0 && t_sk < SNOOP_WIN) && (t_op == RD);
                end
                e_rsp_cyc = cyc + L;
            end
            default: L = 0;
        endcase
        m_free_at = cyc + L + 1;
    endtask

    task automatic commit();
        if (cyc == e_rsp_cyc) begin h_pid = e_pid; h_data = e_data; h_sh = e_sh; end
        if (reset) begin
            model_reset();
            m_free_at = cyc + 1;
        end else if (x_ready != 2'b00) begin
            handshake(x_ready[1] ? 1 : 0);
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        commit();
        #1;
        cyc++;
    endtask

    task automatic req(input int core, input logic [2:0] op, input logic [3:0] a, input logic [7:0] d,
                       input int fk, input int sk, input logic [7:0] fd, input bit junk);
        p_valid[core] = 1'b1; p_op[core] = op; p_addr[core] = a; p_data[core] = d;
        s_fk[core] = fk; s_sk[core] = sk; s_fd[core] = fd; s_junk[core] = junk;
    endtask

    task automatic run();
        int n;
        n = 0;
        while ((p_valid[0] || p_valid[1] || cyc < m_free_at) && n < 200) begin
            step(); n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL run_timeout: still busy at cycle %0d, required idle", cyc);
        end
        step();
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("busy", busy, x_busy);
            chk("req_ready", req_ready, x_ready);
            chk("snp_req_valid", snp_req_valid, x_snp);
            if (x_snp) begin
                chk("snp_req_pid", snp_req_pid, t_pid);
                chk("snp_req_op", snp_req_op, t_op);
                chk("snp_req_addr", snp_req_addr, t_addr);
            end
            chk("rsp_valid", rsp_valid, x_rsp);
            if (x_rsp) begin
                chk("rsp_pid", rsp_pid, e_pid);
                chk("rsp_data", rsp_data, e_data);
                chk("rsp_shared", rsp_shared, e_sh);
            end else begin
                chk("rsp_pid_hold", rsp_pid, h_pid);
                chk("rsp_data_hold", rsp_data, h_data);
                chk("rsp_shared_hold", rsp_shared, h_sh);
            end
            if (rsp_valid) begin
                obs_q.push_back(int'(rsp_pid));
                obs_cyc = cyc; obs_data = rsp_data; obs_sh = rsp_shared; nobs++;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
    endtask

    initial begin
        int n, nb;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p_valid[i] = 0; p_op[i] = 0; p_addr[i] = 0; p_data[i] = 0;
            s_fk[i] = -1; s_sk[i] = -1; s_fd[i] = 0; s_junk[i] = 0;
        end
        model_reset(); m_free_at = 0; nobs = 0;
        step();
        started = 1'b1;
        step(); reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 8'h00);

        // core0 BusRd 0x0, memory path
        req(0, RD, 4'h0, 8'h00, -1, -1, 8'h00, 0); run();
        chk("t1_latency", obs_cyc - t_hs, 6);
        chk("t1_data", obs_data, 8'hFF);
        chk("t1_shared", obs_sh, 0);

        // simultaneous pairs
        do_reset(); obs_q.delete();
        req(0, RD, 4'h1, 8'h00, -1, -1, 8'h00, 0);
        req(1, RD, 4'h5, 8'h00, -1, -1, 8'h00, 0); run();
        chk("pair1_count", obs_q.size(), 2);
        chk("pair1_first", obs_q[0], 0);
        chk("pair1_second", obs_q[1], 1);
        req(0, RD, 4'h2, 8'h00, -1, -1, 8'h00, 0); run();
        obs_q.delete();
        req(0, RD, 4'h1, 8'h00, -1, -1, 8'h00, 0);
        req(1, RD, 4'h5, 8'h00, -1, -1, 8'h00, 0); run();
        chk("pair2_first", obs_q[0], 1);
        chk("pair2_second", obs_q[1], 0);

        // core1 Flush, then core0 reads it back from memory
        req(1, FL, 4'h4, 8'h0A, -1, -1, 8'h00, 0); run();
        req(0, RD, 4'h4, 8'h00, -1, -1, 8'h00, 0); run();
        chk("wb_rd_data", obs_data, 8'h0A);
        chk("wb_rd_shared", obs_sh, 0);

        // peer flush on first SWAIT cycle
        req(0, RD, 4'h4, 8'h00, 0, -1, 8'h1E, 0); run();
        chk("fwd_latency", obs_cyc - t_hs, 3);
        chk("fwd_data", obs_data, 8'h1E);
        chk("fwd_shared", obs_sh, 1);
        req(0, RD, 4'h4, 8'h00, -1, -1, 8'h00, 0); run();
        chk("fwd_mem_update", obs_data, 8'h1E);

        // shared replies; requester's own snoop bits are junk and must be ignored
        req(1, RDX, 4'h3, 8'h00, -1, 0, 8'h00, 1); run();
        chk("rdx_shared", obs_sh, 0);
        chk("rdx_data", obs_data, 8'hFF);
        req(1, RD, 4'h3, 8'h00, -1, 1, 8'h00, 1); run();
        chk("rd_shared", obs_sh, 1);

        // flush and shared in the same (last) SWAIT cycle: flush wins
        req(0, RDX, 4'h5, 8'h00, 1, 1, 8'h5A, 0); run();
        chk("flush_wins_data", obs_data, 8'h5A);
        chk("flush_wins_latency", obs_cyc - t_hs, 4);

        // BusUpgr
        req(0, UPG, 4'h4, 8'h00, -1, -1, 8'h00, 0); run();
        chk("upg_latency", obs_cyc - t_hs, 2);
        chk("upg_data", obs_data, 8'h1E);
        chk("upg_shared", obs_sh, 0);

        // illegal op: accepted and dropped
        nb = nobs;
        req(1, 3'b111, 4'h2, 8'h00, -1, -1, 8'h00, 0); run();
        chk("badop_norsp", nobs, nb);

        // reset during MEM aborts with no response
        req(0, RD, 4'h6, 8'h00, -1, -1, 8'h00, 0);
        step();
        n = 0;
        while (cyc < t_hs + 4 && n < 20) begin step(); n++; end
        nb = nobs;
        reset = 1'b1; step(); reset = 1'b0;
        chk("abort_busy", busy, 0);
        step(); step(); step(); step(); step(); step(); step();
        chk("abort_norsp", nobs, nb);
        req(0, RD, 4'h6, 8'h00, -1, -1, 8'h00, 0); run();
        chk("abort_next_data", obs_data, 8'hFF);
        req(0, RD, 4'h4, 8'h00, -1, -1, 8'h00, 0); run();
        chk("abort_mem_reset", obs_data, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mesi_mem_ctrl.md
Name: mesi_mem_ctrl

Overview:
Shared memory controller and bus arbiter downstream of the two MESI_FSM cache cores. It accepts bus transactions (BusRd, BusRdX, BusUpgr, Flush) from either core and arbitrates them round-robin. It broadcasts a snoop to the peer core and serves data from the peer's flush or from a 16-byte backing memory. It returns one response per data-bearing transaction to the requesting core.

Parameters:
DATA_W, 8, cache block / memory word width in bits
ADDR_W, 4, byte address width (2-bit tag + 2-bit index); memory depth = 2**ADDR_W
MEM_LAT, 2, cycles spent in MEM state for a memory read (legal values ≥1)
SNOOP_WIN, 2, cycles the controller waits for a peer snoop reply (legal values ≥1)

Ports:
clk  in  1  clock; everything is on the rising edge
reset  in  1  synchronous, active-high
req_valid  in  2  bit i = core i has a request pending
req_ready  out  2  bit i = grant to core i; the transfer completes on any edge where req_valid[i]&req_ready[i]
req_op  in  6  core i op at [3i+2:3i]: 001 BusRd, 010 BusRdX, 011 BusUpgr, 100 Flush
req_addr  in  2*ADDR_W  core i address at [ADDR_W*i +: ADDR_W]
req_data  in  2*DATA_W  core i write data (used by Flush only)
snp_req_valid  out  1  snoop broadcast to the non-requesting core
snp_req_pid  out  1  ID of the core that issued the request
snp_req_op  out  3  the op being snooped
snp_req_addr  out  ADDR_W  the address being snooped
snp_flush  in  2  bit i = core i supplies modified data in response to the snoop
snp_shared  in  2  bit i = core i holds a clean copy
snp_data  in  2*DATA_W  flushed data for core i
rsp_valid  out  1  one-cycle response pulse
rsp_pid  out  1  target core of the response
rsp_data  out  DATA_W  returned block
rsp_shared  out  1  1 = requester installs the line Shared; 0 = Exclusive/Modified
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; last_grant=1, so core0 wins the first tie; every memory word = all ones (8'hFF). Reset mid-transaction aborts it and produces no response.
- IDLE:
  - req_ready is combinational: asserted for exactly one core, chosen by round-robin with core (last_grant^1) preferred.
  - On the handshake edge, latch pid/op/addr/data and set last_grant=pid.
  - Next state by op:
    - Flush → WB
    - BusUpgr → UPG
    - BusRd/BusRdX → SNOOP
    - Any other op encoding is accepted, dropped with no response, and the controller returns to IDLE.
- WB (1 cycle): mem[addr]<=data; no response; → IDLE.
- UPG (1 cycle): snp_req_valid=1 (peer invalidates). Next cycle: rsp_valid=1, rsp_data=mem[addr], rsp_shared=0; → IDLE.
- SNOOP (1 cycle): snp_req_valid=1 with pid/op/addr; clear shared_seen; wait counter=0; → SWAIT.
- SWAIT: each cycle, sample the peer's bits only; the requester's own snp_* bits are ignored.
  - snp_flush[peer]=1: mem[addr]<=snp_data[peer]; rsp_data=that data; rsp_shared=(op==BusRd); → RESP. If flush and shared arrive in the same cycle, flush wins.
  - snp_shared[peer]=1: set shared_seen and keep waiting.
  - After SNOOP_WIN cycles with no flush: → MEM.
- MEM: hold for MEM_LAT cycles, then rsp_data=mem[addr], rsp_shared=shared_seen&&(op==BusRd); → RESP.
- RESP (1 cycle): rsp_valid=1, rsp_pid=latched pid; → IDLE. rsp_* keep their values until the next response; rsp_valid is a single-cycle pulse.
- Latency, from the handshake edge to the rsp_valid cycle:
  - Flush via peer on the first SWAIT cycle: 3 cycles.
  - Memory path: 2+SNOOP_WIN+MEM_LAT cycles.
  - BusUpgr: 2 cycles.
- req_ready=0 whenever state≠IDLE, so a request raised mid-transaction waits.
- Counters are sized $clog2(max(MEM_LAT,SNOOP_WIN))+1 bits and never wrap.

Optional Feature:
MESI_MEM_CTRL_STATS_EN
- With the macro defined, the block adds three 16-bit saturating output counters, all cleared by reset:
  - stat_mem_rd: increments on each RESP served from MEM.
  - stat_peer_fwd: increments on each RESP served by a peer flush.
  - stat_wb: increments on each WB.
- Without the macro, these ports and their logic do not exist.

Test Plan:
- Reset, core0 BusRd addr 0x0, no snoop reply → rsp_valid at edge 6 after the handshake (defaults); rsp_pid=0, rsp_data=0xFF, rsp_shared=0.
- Both cores assert BusRd in the same cycle (core0 addr 0x1, core1 addr 0x5) → core0 is served first, then core1. A second simultaneous pair → core1 is served first.
- Core1 Flush addr 0x4 data 0x0A, then core0 BusRd 0x4 → rsp_data=0x0A, rsp_shared=0.
- Core0 BusRd 0x4; peer asserts snp_flush[1] with 0x1E in the first SWAIT cycle → rsp_data=0x1E, rsp_shared=1, mem[4]=0x1E, rsp_valid 3 cycles after the handshake.
- Core1 BusRdX 0x3 with snp_shared[0]=1 → rsp_shared=0. The same case with BusRd → rsp_shared=1.
- Assert reset during MEM → no rsp_valid; busy=0 next cycle; the next BusRd returns 0xFF.
